// File: rtl/md_pkg.sv
// Shared types and widths for the multiply/divide unit.
package md_pkg;

  localparam int unsigned MD_OP_W  = 3;
  localparam int unsigned MD_CNT_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit holding architectural HI/LO; results are computed
// at issue and committed after a fixed latency.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MD_OP_W-1:0]  md_op,
  input  logic [31:0]         src_a,
  input  logic [31:0]         src_b,
  output logic                busy,
  output logic [31:0]         hi,
  output logic [31:0]         lo
);

  md_state_t             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]           pend_hi_q, pend_hi_d;
  logic [31:0]           pend_lo_q, pend_lo_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;

  logic signed [63:0]    a_ext, b_ext, prod_s;
  logic        [63:0]    prod_u;
  logic signed [31:0]    a_s, b_s, quot_s, rem_s;
  logic        [31:0]    b_nz, quot_u, rem_u;
  logic                  div_zero, div_ovf;

  always_comb begin
    a_ext  = {{32{src_a[31]}}, src_a};
    b_ext  = {{32{src_b[31]}}, src_b};
    prod_s = a_ext * b_ext;
    prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Divisor forced non-zero so the dividers never see /0; the real
    // zero and overflow cases are patched in below.
    div_zero = (src_b == '0);
    div_ovf  = (src_a == 32'h8000_0000) && (src_b == '1);
    b_nz     = div_zero ? 32'd1 : src_b;
    a_s      = src_a;
    b_s      = div_ovf ? 32'sd1 : b_nz;
    quot_s   = a_s / b_s;
    rem_s    = a_s % b_s;
    quot_u   = src_a / b_nz;
    rem_u    = src_a % b_nz;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (state_q == MD_IDLE) begin
      if (start) begin
        case (md_op_t'(md_op))
          MD_MULT: begin
            pend_hi_d = prod_s[63:32];
            pend_lo_d = prod_s[31:0];
            cnt_d     = MD_CNT_W'(MULT_CYCLES);
            state_d   = MD_BUSY;
          end
          MD_MULTU: begin
            pend_hi_d = prod_u[63:32];
            pend_lo_d = prod_u[31:0];
            cnt_d     = MD_CNT_W'(MULT_CYCLES);
            state_d   = MD_BUSY;
          end
          MD_DIV: begin
            if (div_zero) begin
              pend_hi_d = src_a;
              pend_lo_d = '1;
            end else if (div_ovf) begin
              pend_hi_d = '0;
              pend_lo_d = 32'h8000_0000;
            end else begin
              pend_hi_d = rem_s;
              pend_lo_d = quot_s;
            end
            cnt_d   = MD_CNT_W'(DIV_CYCLES);
            state_d = MD_BUSY;
          end
          MD_DIVU: begin
            pend_hi_d = div_zero ? src_a : rem_u;
            pend_lo_d = div_zero ? '1 : quot_u;
            cnt_d     = MD_CNT_W'(DIV_CYCLES);
            state_d   = MD_BUSY;
          end
          MD_MTHI: hi_d = src_a;
          MD_MTLO: lo_d = src_a;
          default: ;
        endcase
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == MD_CNT_W'(1)) begin
        hi_d    = pend_hi_q;
        lo_d    = pend_lo_q;
        state_d = MD_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == MD_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
module tb_md_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int failed;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one MULT/DIV-class op and follow it to commit.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] eh, input logic [31:0] el,
                        input string name);
    int cycles;
    @(negedge clk);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      failed++; $display("FAIL %s busy_rise: got %b want 1", name, busy);
    end
    tests++;
    if (hi !== m_hi || lo !== m_lo) begin
      failed++; $display("FAIL %s hold_while_busy: got %h/%h want %h/%h", name, hi, lo, m_hi, m_lo);
    end
    cycles = 1;
    while (busy === 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      if (busy === 1'b1) cycles++;
    end
    tests++;
    if (cycles != n) begin
      failed++; $display("FAIL %s busy_len: got %0d want %0d", name, cycles, n);
    end
    tests++;
    if (hi !== eh) begin
      failed++; $display("FAIL %s hi: got %h want %h", name, hi, eh);
    end
    tests++;
    if (lo !== el) begin
      failed++; $display("FAIL %s lo: got %h want %h", name, lo, el);
    end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; md_op = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failed++; $display("FAIL reset_state: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk); rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 5, 32'h0000_0006, 32'hFFFF_FFEB, "multu");
  endtask

  task automatic test_div;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3, "divu");
    run_op(3'd2, 32'd100, 32'hFFFF_FFF9, 10, 32'd2, 32'hFFFF_FFF2, "div_negdivisor");
  endtask

  task automatic test_div_boundary;
    run_op(3'd2, 32'h1234_5678, 32'd0, 10, 32'h1234_5678, 32'hFFFF_FFFF, "div_by_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, "div_overflow");
    run_op(3'd3, 32'hCAFE_0001, 32'd0, 10, 32'hCAFE_0001, 32'hFFFF_FFFF, "divu_by_zero");
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk);
    start = 1'b1; md_op = 3'd4; src_a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    md_op = 3'd5; src_a = 32'h0BAD_F00D;
    tests++;
    if (hi !== 32'hDEAD_BEEF || busy !== 1'b0) begin
      failed++; $display("FAIL mthi: got hi=%h busy=%b want deadbeef/0", hi, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (lo !== 32'h0BAD_F00D || hi !== 32'hDEAD_BEEF || busy !== 1'b0) begin
      failed++; $display("FAIL mtlo: got hi=%h lo=%h busy=%b want deadbeef/0badf00d/0", hi, lo, busy);
    end
    m_hi = 32'hDEAD_BEEF; m_lo = 32'h0BAD_F00D;
    // Reserved opcode must leave everything untouched.
    @(negedge clk);
    start = 1'b1; md_op = 3'd6; src_a = 32'h5555_5555; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      failed++; $display("FAIL reserved_op: got busy=%b hi=%h lo=%h want 0/%h/%h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_ignore_while_busy;
    int cycles;
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; src_a = 32'd5; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    @(posedge clk); #1;
    cycles++;
    start = 1'b1; md_op = 3'd5; src_a = 32'h1;
    @(posedge clk); #1;
    cycles++;
    md_op = 3'd2; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (lo !== m_lo || busy !== 1'b1) begin
      failed++; $display("FAIL ignore_mtlo: got lo=%h busy=%b want %h/1", lo, busy, m_lo);
    end
    cycles++;
    while (busy === 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      if (busy === 1'b1) cycles++;
    end
    tests++;
    if (cycles != 5) begin
      failed++; $display("FAIL ignore_busy_len: got %0d want 5", cycles);
    end
    tests++;
    if (hi !== 32'h0 || lo !== 32'd45) begin
      failed++; $display("FAIL ignore_result: got %h/%h want 00000000/0000002d", hi, lo);
    end
    m_hi = 32'h0; m_lo = 32'd45;
    // Must stay idle: the ignored DIV must not have been queued.
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || lo !== 32'd45) begin
      failed++; $display("FAIL ignore_no_queue: got busy=%b lo=%h want 0/0000002d", busy, lo);
    end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; src_a = 32'd77; src_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failed++; $display("FAIL async_reset: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk); rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (12) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failed++; $display("FAIL post_reset_idle: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    run_op(3'd3, 32'd1000, 32'd7, 10, 32'd6, 32'd142, "b2b_divu");
    run_op(3'd1, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0, "b2b_multu");
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0, "b2b_mult_min");
  endtask

  initial begin
    tests = 0;
    failed = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_boundary();
    test_mthi_mtlo();
    test_ignore_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
